// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence controller: fetches one 16-bit word from a synchronous IRAM,
// decodes jump/halt opcodes and drives the PC stage with hold/increment/jump commands.
module fetch_sequencer #(
    parameter logic [3:0] JUMP_OP = 4'hE,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] IRAM_data,
    input  logic        exec_done,
    output logic [1:0]  PC_control,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH1, FETCH2, DECODE, EXEC, JUMP, INC, HALT
    } state_t;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;

    state_t state, state_nx;
    logic   from_halt;
    logic   retire;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH1;
            FETCH1:  state_nx = FETCH2;
            FETCH2:  state_nx = DECODE;
            DECODE: begin
                if (instruction[15:12] == HALT_OP)      state_nx = HALT;
                else if (instruction[15:12] == JUMP_OP) state_nx = JUMP;
                else                                    state_nx = EXEC;
            end
            EXEC:    if (exec_done) state_nx = INC;
            JUMP:    state_nx = FETCH1;
            INC:     state_nx = FETCH1;
            HALT:    if (start) state_nx = INC;
            default: state_nx = IDLE;
        endcase
    end

    // The INC that resumes from HALT only steps the PC; it retires nothing.
    assign retire = (state == JUMP) || (state == INC && !from_halt);

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            PC_control  <= PC_HOLD;
            instruction <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            instr_count <= 16'h0000;
            from_halt   <= 1'b0;
        end else begin
            state       <= state_nx;
            instr_valid <= (state_nx == DECODE);
            halted      <= (state_nx == HALT);
            from_halt   <= (state == HALT);
            case (state_nx)
                INC:     PC_control <= PC_INC;
                JUMP:    PC_control <= PC_JUMP;
                default: PC_control <= PC_HOLD;
            endcase
            if (state == FETCH2)
                instruction <= IRAM_data;
            if (retire && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
        end
    end

endmodule
